mac_seq_ctrl: RTL and testbench

MAC_SEQ_CTRL -- requirements
Module: mac_seq_ctrl

---
 rtl/mac_seq_ctrl_pkg.sv | 23 ++
 rtl/mac_seq_ctrl_if.sv | 41 ++++
 rtl/mac_seq_ctrl.sv | 119 +++++++++++
 tb/tb_mac_seq_ctrl.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/mac_seq_ctrl_pkg.sv
// Shared FSM encoding and default geometry for the MAC array sequencer.
// Latency: n/a (declarations only). Backpressure: n/a.
package mac_ctrl_pkg;

    localparam int DEF_ROWS = 4;
    localparam int DEF_COLS = 4;
    localparam int DEF_K_W  = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_W,
        S_STREAM,
        S_FLUSH,
        S_DRAIN,
        S_DONE
    } state_t;

    // Index width for n entries, never narrower than one bit.
    function automatic int addr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mac_seq_ctrl_if.sv
// Job request / PE strobe bundle between the array datapath and its sequencer.
// Latency: n/a (wires only). Backpressure: in_ready stalls input beats.
interface mac_seq_ctrl_if
    import mac_ctrl_pkg::*;
#(
    parameter int K_W  = DEF_K_W,
    parameter int COLS = DEF_COLS
) ();

    localparam int PA_W = addr_w(COLS);

    logic            start;
    logic            mode;
    logic [K_W-1:0]  k_len;
    logic            in_ready;

    logic            pe_mode;
    logic            weight_valid;
    logic [K_W-1:0]  weight_rd_addr;
    logic            input_valid;
    logic [K_W-1:0]  input_rd_addr;
    logic            psum_wr_en;
    logic [PA_W-1:0] psum_wr_addr;
    logic            busy;
    logic            done;

    // Job issuer / datapath side.
    modport master (
        output start, mode, k_len, in_ready,
        input  pe_mode, weight_valid, weight_rd_addr, input_valid, input_rd_addr,
        input  psum_wr_en, psum_wr_addr, busy, done
    );

    // Sequencer side.
    modport slave (
        input  start, mode, k_len, in_ready,
        output pe_mode, weight_valid, weight_rd_addr, input_valid, input_rd_addr,
        output psum_wr_en, psum_wr_addr, busy, done
    );

endinterface

// File: rtl/mac_seq_ctrl.sv
// Sequences weight load, input streaming, skew flush and psum drain for a ROWSxCOLS PE array.
// Latency: done at 1 + (WS ? ROWS : 0) + k_len + stalls + ROWS+COLS-1 + COLS cycles after start.
// Backpressure: in_ready=0 holds STREAM and suppresses that cycle's beat; start is ignored while busy.
module mac_seq_ctrl
    import mac_ctrl_pkg::*;
#(
    parameter int ROWS = DEF_ROWS,
    parameter int COLS = DEF_COLS,
    parameter int K_W  = DEF_K_W
) (
    input  logic           clk,
    input  logic           reset,
    mac_seq_ctrl_if.slave  io
);

    localparam int PA_W  = addr_w(COLS);
    localparam int SK_W  = addr_w(ROWS + COLS);
    localparam int CNT_W = (K_W > SK_W) ? K_W : SK_W;

    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic               mode_q;
    logic [K_W-1:0]     k_q;
    logic               beat;

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_IDLE;
            cnt    <= '0;
            mode_q <= 1'b0;
            k_q    <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (state == S_IDLE && io.start) begin
                mode_q <= io.mode;
                k_q    <= io.k_len;
            end
        end
    end

    // One step counter serves every timed state; it is zeroed on each state exit.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        beat    = (state == S_STREAM) && io.in_ready;
        unique case (state)
            S_IDLE: begin
                cnt_n = '0;
                if (io.start) begin
                    if (io.k_len == '0)
                        state_n = S_DONE;
                    else if (io.mode)
                        state_n = S_LOAD_W;
                    else
                        state_n = S_STREAM;
                end
            end
            S_LOAD_W: begin
                if (cnt == CNT_W'(ROWS - 1)) begin
                    state_n = S_STREAM;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            S_STREAM: begin
                if (beat) begin
                    // Compare against k_len-1 so the all-ones k_len never needs a wider index.
                    if (cnt == CNT_W'(k_q - K_W'(1))) begin
                        state_n = S_FLUSH;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
            end
            S_FLUSH: begin
                if (cnt == CNT_W'(ROWS + COLS - 2)) begin
                    state_n = S_DRAIN;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            S_DRAIN: begin
                if (cnt == CNT_W'(COLS - 1)) begin
                    state_n = S_DONE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
                cnt_n   = '0;
            end
            default: begin
                state_n = S_IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    // Strobes decode the registered state; only STREAM beats also qualify on the
    // same-cycle in_ready so a stalled cycle never issues a beat.
    always_comb begin
        io.pe_mode        = mode_q;
        io.weight_valid   = (state == S_LOAD_W) || (beat && !mode_q);
        io.weight_rd_addr = io.weight_valid ? K_W'(cnt) : '0;
        io.input_valid    = beat;
        io.input_rd_addr  = beat ? K_W'(cnt) : '0;
        io.psum_wr_en     = (state == S_DRAIN);
        io.psum_wr_addr   = io.psum_wr_en ? PA_W'(cnt) : '0;
        io.busy           = (state != S_IDLE);
        io.done           = (state == S_DONE);
    end

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Directed bench for mac_seq_ctrl on a 4x4 array with K_W=8.
module tb_mac_seq_ctrl;
    import mac_ctrl_pkg::*;

    localparam int NMAX = 300;

    logic clk;
    logic reset;

    mac_seq_ctrl_if #(.K_W(8), .COLS(4)) bus ();

    mac_seq_ctrl #(.ROWS(4), .COLS(4), .K_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .io    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    integer r_wv [NMAX];
    integer r_wa [NMAX];
    integer r_iv [NMAX];
    integer r_ia [NMAX];
    integer r_pw [NMAX];
    integer r_pa [NMAX];
    integer r_bz [NMAX];
    integer r_dn [NMAX];
    integer r_pm [NMAX];

    task automatic check_eq(input string tag, input int cyc, input integer got, input integer exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
        end
    endtask

    task automatic record(input int c);
        r_wv[c] = bus.weight_valid;
        r_wa[c] = bus.weight_rd_addr;
        r_iv[c] = bus.input_valid;
        r_ia[c] = bus.input_rd_addr;
        r_pw[c] = bus.psum_wr_en;
        r_pa[c] = bus.psum_wr_addr;
        r_bz[c] = bus.busy;
        r_dn[c] = bus.done;
        r_pm[c] = bus.pe_mode;
    endtask

    // Start in cycle 0; mode/k_len are scrambled afterwards to prove they were latched.
    task automatic run_job(input bit m, input int k, input int n,
                           input int stall_c, input int start2_c, input int rst_c);
        @(posedge clk);
        #1;
        reset        = 1'b0;
        bus.start    = 1'b1;
        bus.mode     = m;
        bus.k_len    = 8'(k);
        bus.in_ready = 1'b1;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            record(c);
            @(posedge clk);
            #1;
            bus.start    = (c + 1 == start2_c);
            bus.mode     = ~m;
            bus.k_len    = 8'(k + 6);
            bus.in_ready = (c + 1 != stall_c);
            reset        = (c + 1 == rst_c);
        end
        bus.start = 1'b0;
        reset     = 1'b0;
    endtask

    // Expected trace of an unstalled job with k >= 1 on a 4x4 array.
    task automatic check_nominal(input string tag, input bit ws, input int k, input int n);
        int s0, s1, d0, dn;
        int ivx, iax, wvx, wax, pwx, pax;
        s0 = ws ? 5 : 1;
        s1 = s0 + k;
        d0 = s1 + 7;
        dn = d0 + 4;
        for (int c = 0; c < n; c++) begin
            ivx = (c >= s0 && c < s1) ? 1 : 0;
            iax = ivx ? c - s0 : 0;
            if (ws) begin
                wvx = (c >= 1 && c <= 4) ? 1 : 0;
                wax = wvx ? c - 1 : 0;
            end else begin
                wvx = ivx;
                wax = iax;
            end
            pwx = (c >= d0 && c < d0 + 4) ? 1 : 0;
            pax = pwx ? c - d0 : 0;
            check_eq({tag, ".weight_valid"},   c, r_wv[c], wvx);
            check_eq({tag, ".weight_rd_addr"}, c, r_wa[c], wax);
            check_eq({tag, ".input_valid"},    c, r_iv[c], ivx);
            check_eq({tag, ".input_rd_addr"},  c, r_ia[c], iax);
            check_eq({tag, ".psum_wr_en"},     c, r_pw[c], pwx);
            check_eq({tag, ".psum_wr_addr"},   c, r_pa[c], pax);
            check_eq({tag, ".busy"},           c, r_bz[c], (c >= 1 && c <= dn) ? 1 : 0);
            check_eq({tag, ".done"},           c, r_dn[c], (c == dn) ? 1 : 0);
            if (c >= 1 && c <= dn)
                check_eq({tag, ".pe_mode"}, c, r_pm[c], ws ? 1 : 0);
        end
    endtask

    task automatic check_all_zero(input string tag, input int c0, input int n);
        for (int c = c0; c < n; c++) begin
            check_eq({tag, ".outs"}, c,
                     r_wv[c] + r_wa[c] + r_iv[c] + r_ia[c] + r_pw[c] + r_pa[c] + r_dn[c] + r_pm[c], 0);
            check_eq({tag, ".busy"}, c, r_bz[c], 0);
        end
    endtask

    initial begin
        reset        = 1'b1;
        bus.start    = 1'b1;
        bus.mode     = 1'b1;
        bus.k_len    = 8'd5;
        bus.in_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        record(0);
        check_all_zero("reset", 0, 1);
        @(posedge clk);
        #1;
        reset     = 1'b0;
        bus.start = 1'b0;

        // WS 4x4 k=3: weights 1-4, inputs 5-7, drain 15-18, done 19.
        run_job(1'b1, 3, 24, -1, -1, -1);
        check_nominal("ws_k3", 1'b1, 3, 24);
        check_eq("ws_k3.wa4",   4,  r_wa[4],  3);
        check_eq("ws_k3.iv7",   7,  r_iv[7],  1);
        check_eq("ws_k3.pa18",  18, r_pa[18], 3);
        check_eq("ws_k3.done19", 19, r_dn[19], 1);

        // OS 4x4 k=5: weight strobes ride with input beats 1-5, done 17.
        run_job(1'b0, 5, 22, -1, -1, -1);
        check_nominal("os_k5", 1'b0, 5, 22);
        check_eq("os_k5.wa5",    5,  r_wa[5],  4);
        check_eq("os_k5.done17", 17, r_dn[17], 1);

        // WS k=3 with in_ready low in cycle 6.
        run_job(1'b1, 3, 24, 6, -1, -1);
        for (int c = 0; c < 24; c++) begin
            check_eq("stall.input_valid", c, r_iv[c], (c == 5 || c == 7 || c == 8) ? 1 : 0);
            check_eq("stall.psum_wr_en",  c, r_pw[c], (c >= 16 && c <= 19) ? 1 : 0);
            check_eq("stall.done",        c, r_dn[c], (c == 20) ? 1 : 0);
        end
        check_eq("stall.ia5", 5, r_ia[5], 0);
        check_eq("stall.ia7", 7, r_ia[7], 1);
        check_eq("stall.ia8", 8, r_ia[8], 2);

        // k=0: straight to DONE in cycle 1, idle in cycle 2.
        run_job(1'b1, 0, 6, -1, -1, -1);
        for (int c = 0; c < 6; c++) begin
            check_eq("k0.strobes", c, r_wv[c] + r_iv[c] + r_pw[c], 0);
            check_eq("k0.busy",    c, r_bz[c], (c == 1) ? 1 : 0);
            check_eq("k0.done",    c, r_dn[c], (c == 1) ? 1 : 0);
        end

        // Start pulse in cycle 10 of a running job is ignored.
        run_job(1'b1, 3, 30, -1, 10, -1);
        check_nominal("start_busy", 1'b1, 3, 30);

        // Reset in cycle 6 aborts the job: quiet from cycle 7, no done.
        run_job(1'b1, 3, 26, -1, -1, 6);
        check_eq("abort.iv5", 5, r_iv[5], 1);
        check_all_zero("abort", 7, 26);
        run_job(1'b1, 3, 24, -1, -1, -1);
        check_nominal("after_abort", 1'b1, 3, 24);

        // Maximum k_len: final address 254, no wrap.
        run_job(1'b0, 255, 280, -1, -1, -1);
        check_nominal("os_kmax", 1'b0, 255, 280);
        check_eq("os_kmax.ia255",   255, r_ia[255], 254);
        check_eq("os_kmax.done267", 267, r_dn[267], 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
